fft_stage_ctrl: RTL and testbench

Sequencing controller for an in-place radix-2 decimation-in-frequency FFT built around one shared `butterfly` datapath and a dual-port synchronous sample RAM. On `start` it walks all LOG2N stages, issuing one butterfly per cycle with read addresses and twiddle index. It drives the butterfly `enable` and issues delayed write-back addresses so results land in place. Results are left in bit-reversed order.

---
 rtl/fft_pkg.sv | 22 ++
 rtl/fft_delay_line.sv | 30 +++
 rtl/fft_stage_ctrl.sv | 138 +++++++++++++
 tb/tb_fft_stage_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared sizing defaults and FSM encoding for the in-place radix-2 DIF FFT
// stage controller.
package fft_pkg;

   localparam int LOG2N_DEF    = 4;
   localparam int PIPE_LAT_DEF = 5;
   localparam int ADDR_W_DEF   = LOG2N_DEF;
   localparam int TW_W_DEF     = LOG2N_DEF - 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_DONE
   } state_e;

   // Bits needed for a counter spanning 0..n-1, never less than one.
   function automatic int cnt_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register that carries the read-side request
// {rd_en, addr_a, addr_b} across the RAM + butterfly latency to the write side.
module fft_delay_line
   import fft_pkg::*;
#(
   parameter int DEPTH = PIPE_LAT_DEF,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o
);

   logic [WIDTH-1:0] pipe_q [DEPTH];

   // NOTE: every tap is cleared, not only the strobe bit -- a stale entry
   // surviving reset would commit a spurious write into the sample RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= din_i;
         for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign dout_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_ctrl.sv
// Stage sequencer for an in-place radix-2 DIF FFT: one butterfly issued per
// cycle, write-back addresses delayed to match the datapath latency.
module fft_stage_ctrl
   import fft_pkg::*;
#(
   parameter int LOG2N    = LOG2N_DEF,
   parameter int PIPE_LAT = PIPE_LAT_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [LOG2N-1:0] stage_o,
   output logic             rd_en_o,
   output logic [LOG2N-1:0] rd_addr_a_o,
   output logic [LOG2N-1:0] rd_addr_b_o,
   output logic [LOG2N-2:0] tw_addr_o,
   output logic             bf_en_o,
   output logic             wr_en_o,
   output logic [LOG2N-1:0] wr_addr_a_o,
   output logic [LOG2N-1:0] wr_addr_b_o
);

   localparam int AW   = LOG2N;
   localparam int TW_W = LOG2N - 1;
   localparam int DW   = cnt_w(PIPE_LAT);
   localparam int WBW  = 1 + 2 * AW;

   localparam logic [AW-2:0] K_LAST = '1;
   localparam logic [AW-1:0] S_LAST = AW'(LOG2N - 1);
   localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);

   state_e        state_q, state_d;
   logic [AW-1:0] s_q, s_d;
   logic [AW-2:0] k_q, k_d;
   logic [DW-1:0] drain_q, drain_d;

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         s_q     <= '0;
         k_q     <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         k_q     <= k_d;
         drain_q <= drain_d;
      end
   end

   always_comb begin
      // NOTE: hold-value defaults first so no branch can infer a latch.
      state_d = state_q;
      s_d     = s_q;
      k_d     = k_q;
      drain_d = drain_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_ISSUE;
               s_d     = '0;
               k_d     = '0;
            end
         end
         ST_ISSUE: begin
            if (k_q == K_LAST) begin
               state_d = ST_DRAIN;
               drain_d = '0;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (drain_q == D_LAST) begin
               if (s_q == S_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ISSUE;
                  s_d     = s_q + 1'b1;
                  k_d     = '0;
               end
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            s_d     = '0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // half = N >> (s+1) = 1 << sh; j = k mod half; g = k / half.
   logic [AW-1:0]   sh, half, k_ext, j, g, a_addr;
   logic [TW_W-1:0] tw;

   always_comb begin
      sh     = S_LAST - s_q;
      half   = AW'(1) << sh;
      k_ext  = {1'b0, k_q};
      j      = k_ext & (half - AW'(1));
      g      = k_ext >> sh;
      a_addr = (g << (sh + AW'(1))) | j;
      tw     = TW_W'(j << s_q);
   end

   logic issue, drain;
   assign issue = (state_q == ST_ISSUE);
   assign drain = (state_q == ST_DRAIN);

   assign rd_en_o     = issue;
   assign rd_addr_a_o = issue ? a_addr : '0;
   assign rd_addr_b_o = issue ? (a_addr | half) : '0;
   assign tw_addr_o   = issue ? tw : '0;
   assign busy_o      = issue | drain;
   assign bf_en_o     = issue | drain;
   assign done_o      = (state_q == ST_DONE);
   assign stage_o     = s_q;

   logic [WBW-1:0] wb_out;

   fft_delay_line #(
      .DEPTH (PIPE_LAT),
      .WIDTH (WBW)
   ) u_wb_delay (
      .clk    (clk),
      .rst_n  (rst_n),
      .din_i  ({rd_en_o, rd_addr_a_o, rd_addr_b_o}),
      .dout_o (wb_out)
   );

   assign {wr_en_o, wr_addr_a_o, wr_addr_b_o} = wb_out;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Self-checking bench for fft_stage_ctrl (N=16, PIPE_LAT=5): cycle-accurate
// address/strobe model plus a write-back scoreboard fed from expected reads.
module tb_fft_stage_ctrl;

   localparam int LOG2N  = 4;
   localparam int PL     = 5;
   localparam int NN     = 1 << LOG2N;
   localparam int HALF_N = NN / 2;
   localparam int PER    = HALF_N + PL;
   localparam int DONE_T = LOG2N * PER + 1;

   typedef struct {
      int s;
      int k;
      int a;
      int b;
      int tw;
   } vec_t;

   typedef struct {
      int due;
      int a;
      int b;
   } wb_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             start = 1'b0;
   logic             busy, done, rd_en, bf_en, wr_en;
   logic [LOG2N-1:0] stage, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
   logic [LOG2N-2:0] tw_addr;

   int  vectors = 0;
   int  miscompares = 0;
   int  cyc = 0;
   vec_t vecs [6];
   wb_t  wb_q [$];

   fft_stage_ctrl #(
      .LOG2N    (LOG2N),
      .PIPE_LAT (PL)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start),
      .busy_o      (busy),
      .done_o      (done),
      .stage_o     (stage),
      .rd_en_o     (rd_en),
      .rd_addr_a_o (rd_addr_a),
      .rd_addr_b_o (rd_addr_b),
      .tw_addr_o   (tw_addr),
      .bf_en_o     (bf_en),
      .wr_en_o     (wr_en),
      .wr_addr_a_o (wr_addr_a),
      .wr_addr_b_o (wr_addr_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},  busy, 0);
      check({tag, "_done"},  done, 0);
      check({tag, "_stage"}, stage, 0);
      check({tag, "_rd_en"}, rd_en, 0);
      check({tag, "_rd_a"},  rd_addr_a, 0);
      check({tag, "_rd_b"},  rd_addr_b, 0);
      check({tag, "_tw"},    tw_addr, 0);
      check({tag, "_bf_en"}, bf_en, 0);
      check({tag, "_wr_en"}, wr_en, 0);
      check({tag, "_wr_a"},  wr_addr_a, 0);
      check({tag, "_wr_b"},  wr_addr_b, 0);
   endtask

   task automatic sb_check();
      bit  exp_wr;
      wb_t e;
      exp_wr = (wb_q.size() > 0) && (wb_q[0].due == cyc);
      check("wr_en", wr_en, exp_wr);
      if (exp_wr) begin
         e = wb_q.pop_front();
         check("wr_addr_a", wr_addr_a, e.a);
         check("wr_addr_b", wr_addr_b, e.b);
      end
   endtask

   // t is the cycle index relative to the edge that sampled start (t=0).
   task automatic check_cycle(input int t);
      int s, w, k, half, j, g, ea;
      bit bsy, iss;
      bsy = (t >= 1) && (t < DONE_T);
      s   = bsy ? (t - 1) / PER : 0;
      w   = bsy ? (t - 1) % PER : 0;
      iss = bsy && (w < HALF_N);
      check("busy",  busy,  bsy);
      check("bf_en", bf_en, bsy);
      check("done",  done,  t == DONE_T);
      check("rd_en", rd_en, iss);
      if (bsy) check("stage", stage, s);
      if (iss) begin
         k    = w;
         half = NN >> (s + 1);
         j    = k % half;
         g    = k / half;
         ea   = 2 * half * g + j;
         check("rd_addr_a", rd_addr_a, ea);
         check("rd_addr_b", rd_addr_b, ea + half);
         check("tw_addr",   tw_addr,   (j << s) % HALF_N);
         foreach (vecs[i]) begin
            if (vecs[i].s == s && vecs[i].k == k) begin
               check("tbl_a",  rd_addr_a, vecs[i].a);
               check("tbl_b",  rd_addr_b, vecs[i].b);
               check("tbl_tw", tw_addr,   vecs[i].tw);
            end
         end
         wb_q.push_back('{cyc + PL, ea, ea + half});
      end
      sb_check();
   endtask

   task automatic run_transform(input bit hold);
      start = 1'b1;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      for (int t = 1; t <= DONE_T + 1; t++) begin
         check_cycle(t);
         if (t <= DONE_T) begin
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      vecs[0] = '{0, 0, 0,  8, 0};
      vecs[1] = '{0, 7, 7, 15, 7};
      vecs[2] = '{1, 4, 8, 12, 0};
      vecs[3] = '{1, 5, 9, 13, 2};
      vecs[4] = '{2, 5, 9, 11, 4};
      vecs[5] = '{3, 3, 6,  7, 0};

      #1 rst_n = 1'b0;
      #2 check_all_zero("reset");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Single-pulse start, full transform.
      run_transform(1'b0);
      check("sb_empty_1", wb_q.size(), 0);

      // Start held high: ignored while busy, restarts on the first IDLE cycle.
      run_transform(1'b1);
      run_transform(1'b0);
      check("sb_empty_2", wb_q.size(), 0);

      // Reset during stage 1 (cycle 20): outputs drop at once, no further writes.
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int t = 1; t < 20; t++) begin
         check_cycle(t);
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1 check_all_zero("midrst");
      wb_q.delete();
      repeat (2) begin
         @(posedge clk); #1;
         check("rst_hold_wr_en", wr_en, 0);
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         check_cycle(DONE_T + 1);
      end

      // Fresh start after the aborted transform.
      run_transform(1'b0);
      check("sb_empty_3", wb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
